// File: rtl/wb_axilite_bridge_if.sv
// Bus bundle between a qualified Wishbone request port and an AXI4-Lite register slave.
// The bridge uses the slave modport; the surrounding environment uses the master modport.
interface wb_axilite_bridge_if #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32
);
    localparam int STRB_W = pDATA_WIDTH / 8;

    logic [31:0]             wbs_adr_i;
    logic                    wb_valid;
    logic                    wbs_we_i;
    logic [STRB_W-1:0]       wbs_sel_i;
    logic [pDATA_WIDTH-1:0]  wbs_dat_i;
    logic                    wb_ready;
    logic                    wb_err;
    logic [pDATA_WIDTH-1:0]  wbs_dat_o;

    logic                    awvalid;
    logic                    awready;
    logic [pADDR_WIDTH-1:0]  awaddr;
    logic                    wvalid;
    logic                    wready;
    logic [pDATA_WIDTH-1:0]  wdata;
    logic [STRB_W-1:0]       wstrb;
    logic                    bvalid;
    logic                    bready;
    logic [1:0]              bresp;
    logic                    arvalid;
    logic                    arready;
    logic [pADDR_WIDTH-1:0]  araddr;
    logic                    rvalid;
    logic                    rready;
    logic [pDATA_WIDTH-1:0]  rdata;
    logic [1:0]              rresp;

    // Bridge side: Wishbone slave, AXI-Lite master.
    modport slave (
        input  wbs_adr_i, wb_valid, wbs_we_i, wbs_sel_i, wbs_dat_i,
        output wb_ready, wb_err, wbs_dat_o,
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport master (
        output wbs_adr_i, wb_valid, wbs_we_i, wbs_sel_i, wbs_dat_i,
        input  wb_ready, wb_err, wbs_dat_o,
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/wb_axilite_bridge.sv
// Wishbone-slave to AXI4-Lite-master bridge, one outstanding transaction, registered ack.
// Optional per-transaction timeout is enabled by defining WB_AXIL_TIMEOUT_EN.
module wb_axilite_bridge #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int pTIMEOUT    = 255
) (
    input logic clk,
    input logic rst,
    wb_axilite_bridge_if.slave bus
);
    localparam int STRB_W = pDATA_WIDTH / 8;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        ACK
    } state_t;

    state_t state;
    state_t state_nxt;

    logic                   aw_done;
    logic                   w_done;
    logic                   aw_hs;
    logic                   w_hs;
    logic                   timeout;
    logic [pADDR_WIDTH-1:0] awaddr_q;
    logic [pADDR_WIDTH-1:0] araddr_q;
    logic [pDATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]      wstrb_q;
    logic [pDATA_WIDTH-1:0] rdata_q;
    logic                   err_q;
    logic                   unused_bits;

    assign aw_hs = bus.awvalid & bus.awready;
    assign w_hs  = bus.wvalid & bus.wready;

`ifdef WB_AXIL_TIMEOUT_EN
    localparam int CNT_W = $clog2(pTIMEOUT + 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             busy;

    assign busy = (state == WR_REQ) || (state == WR_RESP) ||
                  (state == RD_REQ) || (state == RD_RESP);

    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    // Fires on the last of the pTIMEOUT busy cycles, so ACK lands one cycle later.
    assign timeout = busy && (tmo_cnt == CNT_W'(pTIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.wb_valid) begin
                    state_nxt = bus.wbs_we_i ? WR_REQ : RD_REQ;
                end
            end
            WR_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                    state_nxt = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bus.bvalid) begin
                    state_nxt = ACK;
                end
            end
            RD_REQ: begin
                if (bus.arready) begin
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (bus.rvalid) begin
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (timeout) begin
            state_nxt = ACK;
        end
    end

    // AW and W complete independently; remember which one finished first.
    always_ff @(posedge clk) begin
        if (rst || (state != WR_REQ)) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_done <= 1'b1;
            end
            if (w_hs) begin
                w_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            awaddr_q <= '0;
            araddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if ((state == IDLE) && bus.wb_valid) begin
                awaddr_q <= bus.wbs_adr_i[pADDR_WIDTH-1:0];
                araddr_q <= bus.wbs_adr_i[pADDR_WIDTH-1:0];
                wdata_q  <= bus.wbs_dat_i;
                wstrb_q  <= bus.wbs_sel_i;
                rdata_q  <= '0;
                err_q    <= 1'b0;
            end
            if (timeout) begin
                rdata_q <= '0;
                err_q   <= 1'b1;
            end else if ((state == WR_RESP) && bus.bvalid) begin
                err_q <= bus.bresp[1];
            end else if ((state == RD_RESP) && bus.rvalid) begin
                rdata_q <= bus.rdata;
                err_q   <= bus.rresp[1];
            end
        end
    end

    // Every handshake output is a decode of registered state, so none glitch on slave inputs.
    always_comb begin
        bus.awvalid   = (state == WR_REQ) && !aw_done;
        bus.wvalid    = (state == WR_REQ) && !w_done;
        bus.bready    = (state == WR_RESP);
        bus.arvalid   = (state == RD_REQ);
        bus.rready    = (state == RD_RESP);
        bus.awaddr    = awaddr_q;
        bus.araddr    = araddr_q;
        bus.wdata     = wdata_q;
        bus.wstrb     = wstrb_q;
        bus.wb_ready  = (state == ACK);
        bus.wb_err    = (state == ACK) && err_q;
        bus.wbs_dat_o = (state == ACK) ? rdata_q : '0;
    end

    assign unused_bits = ^{bus.wbs_adr_i[31:pADDR_WIDTH], bus.bresp[0], bus.rresp[0],
                           (pTIMEOUT == 0)};

endmodule

// File: tb/tb_wb_axilite_bridge.sv
// Directed bench for wb_axilite_bridge: zero-wait and stalled writes/reads, error responses,
// mid-transaction reset and (with WB_AXIL_TIMEOUT_EN) the transaction timeout.
module tb_wb_axilite_bridge;
    localparam int AW  = 12;
    localparam int DW  = 32;
    localparam int TMO = 16;

    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    logic        seen;
    int          cycles;
    logic [31:0] dat;
    logic        err;
    int          cnt;

    wb_axilite_bridge_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) bus ();

    wb_axilite_bridge #(
        .pADDR_WIDTH(AW),
        .pDATA_WIDTH(DW),
        .pTIMEOUT   (TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic we, input logic [31:0] adr,
                                 input logic [3:0] sel, input logic [31:0] wdat);
        bus.wb_valid  = valid;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = adr;
        bus.wbs_sel_i = sel;
        bus.wbs_dat_i = wdat;
    endtask

    task automatic setSlave(input logic awr, input logic wr, input logic bv, input logic [1:0] br,
                            input logic arr, input logic rv, input logic [1:0] rr,
                            input logic [31:0] rd);
        bus.awready = awr;
        bus.wready  = wr;
        bus.bvalid  = bv;
        bus.bresp   = br;
        bus.arready = arr;
        bus.rvalid  = rv;
        bus.rresp   = rr;
        bus.rdata   = rd;
    endtask

    // Steps until wb_ready is seen (bounded); leaves the bench in the ack cycle.
    task automatic waitAck(input int limit, output logic ok, output int n,
                           output logic [31:0] d, output logic e);
        ok = 1'b0;
        n  = 0;
        d  = '0;
        e  = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            step();
            if (bus.wb_ready === 1'b1) begin
                ok = 1'b1;
                n  = i;
                d  = bus.wbs_dat_o;
                e  = bus.wb_err;
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        step();
        step();
        checkOutput("reset_valids", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready}, 5'b0);
        checkOutput("reset_ack", {bus.wb_ready, bus.wb_err}, 2'b00);
        checkOutput("reset_rdata", bus.wbs_dat_o, 32'h0);
        checkOutput("reset_addr", {bus.awaddr, bus.araddr}, 24'h0);
        checkOutput("reset_wdata", {bus.wdata, bus.wstrb}, 36'h0);
        rst = 1'b0;
        step();

        $display("[TB] write, zero-wait slave");
        setSlave(1'b1, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h3000_0010, 4'hF, 32'hDEAD_BEEF);
        step();
        checkOutput("t1_valids", {bus.awvalid, bus.wvalid}, 2'b11);
        checkOutput("t1_awaddr", bus.awaddr, 12'h010);
        checkOutput("t1_wdata", bus.wdata, 32'hDEAD_BEEF);
        checkOutput("t1_wstrb", bus.wstrb, 4'hF);
        waitAck(10, seen, cycles, dat, err);
        checkOutput("t1_ack_seen", seen, 1'b1);
        checkOutput("t1_latency", 1 + cycles, 3);
        checkOutput("t1_err", err, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        step();
        checkOutput("t1_ack_pulse", bus.wb_ready, 1'b0);

        $display("[TB] read, delayed arready and rvalid");
        applyStimulus(1'b1, 1'b0, 32'h3000_0020, 4'h0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            cnt += int'(bus.arvalid);
        end
        step();
        cnt += int'(bus.arvalid);
        checkOutput("t2_araddr", bus.araddr, 12'h020);
        bus.arready = 1'b1;
        step();
        bus.arready = 1'b0;
        checkOutput("t2_arvalid_cycles", cnt, 5);
        checkOutput("t2_handoff", {bus.arvalid, bus.rready}, 2'b01);
        step();
        checkOutput("t2_rready_wait", {bus.rready, bus.wb_ready}, 2'b10);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'h1234_5678;
        step();
        bus.rvalid = 1'b0;
        checkOutput("t2_ack", {bus.wb_ready, bus.wb_err, bus.rready}, 3'b100);
        checkOutput("t2_rdata", bus.wbs_dat_o, 32'h1234_5678);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        checkOutput("t2_after_ack", {bus.wb_ready, bus.wbs_dat_o}, 33'h0);

        $display("[TB] write, W completes before AW");
        setSlave(1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h3000_0044, 4'h3, 32'hCAFE_0001);
        step();
        checkOutput("t3_valids_c1", {bus.awvalid, bus.wvalid}, 2'b11);
        checkOutput("t3_wstrb", bus.wstrb, 4'h3);
        step();
        bus.wready = 1'b0;
        checkOutput("t3_valids_c2", {bus.awvalid, bus.wvalid}, 2'b10);
        step();
        checkOutput("t3_valids_c3", {bus.awvalid, bus.wvalid, bus.bready}, 3'b100);
        step();
        bus.awready = 1'b1;
        step();
        bus.awready = 1'b0;
        checkOutput("t3_to_resp", {bus.awvalid, bus.wvalid, bus.bready}, 3'b001);
        bus.bvalid = 1'b1;
        waitAck(10, seen, cycles, dat, err);
        checkOutput("t3_ack_seen", seen, 1'b1);
        checkOutput("t3_err", err, 1'b0);
        bus.bvalid = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            cnt += int'(bus.wb_ready);
        end
        checkOutput("t3_single_ack", cnt, 0);

        $display("[TB] read error response then clean read");
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b10, 32'hAAAA_5555);
        applyStimulus(1'b1, 1'b0, 32'h3000_0008, 4'h0, 32'h0);
        waitAck(10, seen, cycles, dat, err);
        checkOutput("t4a_ack_seen", seen, 1'b1);
        checkOutput("t4a_latency", cycles, 3);
        checkOutput("t4a_err", err, 1'b1);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 32'h0BAD_F00D);
        applyStimulus(1'b1, 1'b0, 32'h3000_000C, 4'h0, 32'h0);
        waitAck(10, seen, cycles, dat, err);
        checkOutput("t4b_ack_seen", seen, 1'b1);
        checkOutput("t4b_err", err, 1'b0);
        checkOutput("t4b_rdata", dat, 32'h0BAD_F00D);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();

        $display("[TB] reset during write response");
        setSlave(1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'h3000_0050, 4'hF, 32'h0000_0055);
        step();
        step();
        checkOutput("t5_in_resp", bus.bready, 1'b1);
        rst = 1'b1;
        step();
        checkOutput("t5_ctrl_zero", {bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                                     bus.wb_ready, bus.wb_err}, 7'b0);
        checkOutput("t5_data_zero", {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb}, 60'h0);
        checkOutput("t5_rdata_zero", bus.wbs_dat_o, 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            cnt += int'(bus.wb_ready);
        end
        checkOutput("t5_no_ack", cnt, 0);
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 32'h600D_CAFE);
        applyStimulus(1'b1, 1'b0, 32'h3000_0014, 4'h0, 32'h0);
        waitAck(10, seen, cycles, dat, err);
        checkOutput("t5_read_seen", seen, 1'b1);
        checkOutput("t5_read_latency", cycles, 3);
        checkOutput("t5_read_data", dat, 32'h600D_CAFE);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        step();

`ifdef WB_AXIL_TIMEOUT_EN
        $display("[TB] read timeout, arready never asserted");
        applyStimulus(1'b1, 1'b0, 32'h3000_0060, 4'h0, 32'h0);
        waitAck(40, seen, cycles, dat, err);
        checkOutput("t6_ack_seen", seen, 1'b1);
        checkOutput("t6_latency", cycles, 17);
        checkOutput("t6_err", err, 1'b1);
        checkOutput("t6_rdata", dat, 32'h0);
        checkOutput("t6_arvalid_dropped", bus.arvalid, 1'b0);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        step();
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hFFFF_FFFF;
        step();
        step();
        bus.rvalid = 1'b0;
        checkOutput("t6_late_rvalid", {bus.wb_ready, bus.rready, bus.arvalid}, 3'b000);
`else
        $display("[TB] read with stalled arready waits indefinitely");
        applyStimulus(1'b1, 1'b0, 32'h3000_0060, 4'h0, 32'h0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            cnt += int'(bus.wb_ready);
        end
        checkOutput("t6_no_ack", cnt, 0);
        checkOutput("t6_arvalid_held", bus.arvalid, 1'b1);
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 32'h7777_0001);
        waitAck(10, seen, cycles, dat, err);
        checkOutput("t6_ack_seen", seen, 1'b1);
        checkOutput("t6_latency", cycles, 2);
        checkOutput("t6_rdata", dat, 32'h7777_0001);
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        setSlave(1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 32'h0);
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/wb_axilite_bridge.md
Name: wb_axilite_bridge

Overview:
- Parametrised Wishbone-slave to AXI4-Lite-master bridge.
- Sits between the user-project Wishbone decode (wb_valid already qualified by cyc/stb/address window) and AXI-Lite register slaves (FIR config, etc.).
- Full AXI-Lite protocol: independent AW/W handshakes, B and R response channels, byte strobes, response-error reporting.
- Only one outstanding transaction, with registered Wishbone acknowledge.

Parameters:
- pADDR_WIDTH, 12, AXI address width; low bits of wbs_adr_i forwarded.
- pDATA_WIDTH, 32, data width; must be a multiple of 8.
- pTIMEOUT, 255, cycles allowed per AXI transaction before forced termination (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- wbs_adr_i  in  32  Wishbone byte address
- wb_valid  in  1  qualified Wishbone request (cyc & stb & window)
- wbs_we_i  in  1  1 = write
- wbs_sel_i  in  pDATA_WIDTH/8  byte selects
- wbs_dat_i  in  pDATA_WIDTH  write data
- wb_ready  out  1  registered ack, 1-cycle pulse
- wb_err  out  1  error flag, valid only while wb_ready=1
- wbs_dat_o  out  pDATA_WIDTH  read data, valid while wb_ready=1, else 0
- awvalid  out  1;  awready  in  1;  awaddr  out  pADDR_WIDTH
- wvalid  out  1;  wready  in  1;  wdata  out  pDATA_WIDTH;  wstrb  out  pDATA_WIDTH/8
- bvalid  in  1;  bready  out  1;  bresp  in  2
- arvalid  out  1;  arready  in  1;  araddr  out  pADDR_WIDTH
- rvalid  in  1;  rready  out  1;  rdata  in  pDATA_WIDTH;  rresp  in  2

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: all outputs 0, including address and data registers; state IDLE.
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, ACK.
- IDLE:
  - On wb_valid=1, latch awaddr/araddr = wbs_adr_i[pADDR_WIDTH-1:0], wdata = wbs_dat_i, wstrb = wbs_sel_i.
  - wbs_we_i=1 → WR_REQ with awvalid=wvalid=1 next cycle.
  - wbs_we_i=0 → RD_REQ with arvalid=1.
- WR_REQ:
  - awvalid drops the cycle after awready&awvalid; wvalid drops the cycle after wready&wvalid. The two may complete in either order or the same cycle.
  - When both are done → WR_RESP with bready=1.
- WR_RESP: on bvalid → ACK; wb_err = bresp[1]; bready drops.
- RD_REQ: on arready → RD_RESP with rready=1, arvalid=0.
- RD_RESP: on rvalid → ACK; capture wbs_dat_o = rdata and wb_err = rresp[1]; rready drops.
- ACK: wb_ready=1 for exactly one cycle → IDLE. In the following cycle wbs_dat_o=0 and wb_err=0.
- Stability: addresses, data and strobes are held stable while their valid is high.
- Master requirement: wb_valid is removed in the cycle after wb_ready. Any wb_valid while not in IDLE is ignored.
- Minimum latency, zero-wait slave: wb_valid sampled at edge 0 → valids high cycle 1 → bready/rready cycle 2 → wb_ready cycle 3.
- wbs_sel_i=0 write: still issued, with wstrb=0.
- Reset mid-transaction: all valids/readies low and IDLE after the reset edge; no ack issued. Slaves share rst.

Optional Feature:
- Macro: WB_AXIL_TIMEOUT_EN.
- Enabled:
  - Counter clears in IDLE and increments every cycle in WR_REQ/WR_RESP/RD_REQ/RD_RESP.
  - When it reaches pTIMEOUT: drop all valids/readies, go to ACK with wb_err=1 and wbs_dat_o=0.
  - Late bvalid/rvalid arriving after a timeout are ignored in IDLE.
- Disabled: no counter; the bridge waits indefinitely.

Test Plan:
- Write, zero-wait slave: adr 0x3000_0010, dat 0xDEAD_BEEF, sel 0xF → awaddr=0x010, wdata=0xDEAD_BEEF, wstrb=0xF; wb_ready exactly 3 cycles after request; wb_err=0.
- Read, arready delayed 4 cycles and rvalid delayed 2, rdata=0x1234_5678 → arvalid held 5 cycles; wbs_dat_o=0x1234_5678 during the single wb_ready cycle, 0 after.
- Write, wready 3 cycles before awready, sel 0x3 → each valid drops independently after its own handshake; wstrb=0x3; one ack only.
- Read with rresp=2'b10 → wb_ready=1 with wb_err=1; next read with rresp=0 → wb_err=0.
- rst asserted while in WR_RESP → all outputs 0 the next cycle; no wb_ready; a new read then completes normally.
- WB_AXIL_TIMEOUT_EN, pTIMEOUT=16, arready never asserted → arvalid drops and wb_ready+wb_err assert 17 cycles after the request; wbs_dat_o=0.
